// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, command/response records and sequencer states.
package alu_seq_pkg;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int TAG_W  = 4;
  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [SEL_W-1:0]  s;
    logic              m;
    logic              cin;
    logic [TAG_W-1:0]  tag;
  } alu_cmd_t;
  typedef struct packed {
    logic [DATA_W-1:0] out;
    logic              cout;
    logic              aeb;
    logic [TAG_W-1:0]  tag;
  } alu_rsp_t;
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} seq_state_e;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO; a push becomes visible at the head one cycle later.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  alu_cmd_t      din_i,
  input  logic          pop_i,
  output alu_cmd_t      dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  alu_cmd_t      mem_q [DEPTH];
  logic          do_push, do_pop;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;
  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands, drives the ALU from registers and
// returns each settled result, tagged, on a valid/ready response port.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_in1,
  input  logic [DATA_W-1:0] cmd_in2,
  input  logic [SEL_W-1:0]  cmd_s,
  input  logic              cmd_m,
  input  logic              cmd_cin,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [SEL_W-1:0]  alu_s,
  output logic              alu_m,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  input  logic              alu_aeb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_cout,
  output logic              rsp_aeb,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [CW-1:0]     fifo_count
);
  seq_state_e       state_q, state_d;
  alu_cmd_t         issue_q, head, push_cmd;
  alu_rsp_t         rsp_q;
  logic             rsp_valid_q;
  logic [TAG_W-1:0] tag_q;
  logic             push, pop, hs, full, empty;
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign push_cmd  = '{in1: cmd_in1, in2: cmd_in2, s: cmd_s, m: cmd_m, cin: cmd_cin, tag: tag_q};
  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .din_i  (push_cmd),
    .pop_i  (pop),
    .dout_o (head),
    .count_o(fifo_count),
    .full_o (full),
    .empty_o(empty)
  );
  always_comb begin
    hs      = state_q == RESP && rsp_ready;
    pop     = !empty && (state_q == IDLE || hs);
    state_d = pop ? DRIVE : state_q == DRIVE ? RESP : hs ? IDLE : state_q;
  end
  // alu_* only change on a pop, so they hold the last command while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_q     <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= state_d == RESP;
      if (push) tag_q <= tag_q + 1'b1;
      if (pop) issue_q <= head;
      if (state_q == DRIVE) rsp_q <= '{out: alu_out, cout: alu_cout, aeb: alu_aeb, tag: issue_q.tag};
    end
  end
  assign alu_in1   = issue_q.in1;
  assign alu_in2   = issue_q.in2;
  assign alu_s     = issue_q.s;
  assign alu_m     = issue_q.m;
  assign alu_cin   = issue_q.cin;
  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_q.out;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_aeb   = rsp_q.aeb;
  assign rsp_tag   = rsp_q.tag;
endmodule
